ddr3_ui_responder: RTL and testbench

DDR3_UI_RESPONDER -- requirements
Module: ddr3_ui_responder

---
 rtl/ddr3_ui_responder.sv | 234 +++++++++++++++++++++++
 tb/tb_ddr3_ui_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_ui_responder.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_ui_responder
// Brief    : Behavioural user-interface responder for a DDR3 controller.
//            Accepts write/read commands and write beats, commits beats to
//            a backing RAM, returns read beats after a fixed latency and
//            inserts periodic or requested refresh windows.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_ui_responder #(
    parameter int ADDR_W       = 29,
    parameter int DATA_W       = 256,
    parameter int MEM_AW       = 8,
    parameter int RD_LAT       = 4,
    parameter int INIT_CYCLES  = 16,
    parameter int REF_INTERVAL = 200,
    parameter int REF_LEN      = 6
) (
    input  logic                  ui_clk,
    input  logic                  ui_clk_sync_rst,
    input  logic [2:0]            cmd,
    input  logic                  cmd_en,
    input  logic [ADDR_W-1:0]     addr,
    output logic                  cmd_ready,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_data_en,
    input  logic                  wr_data_end,
    input  logic [DATA_W/8-1:0]   wr_data_mask,
    output logic                  wr_data_rdy,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_data_valid,
    output logic                  rd_data_end,
    input  logic                  ref_req,
    output logic                  ref_ack,
    output logic                  init_calib_complete,
    output logic                  err
);

    localparam int          c_depth    = 2 ** MEM_AW;
    localparam int          c_bytes    = DATA_W / 8;
    localparam logic [15:0] c_init_last = 16'(INIT_CYCLES - 1);
    localparam logic [15:0] c_ref_last  = 16'(REF_INTERVAL - 1);
    localparam logic [15:0] c_len_last  = 16'(REF_LEN - 1);

    typedef enum logic [0:0] {REF_IDLE = 1'b0, REF_BUSY = 1'b1} ref_state_t;

    logic [DATA_W-1:0]  r_ram [c_depth];
    logic               r_init_done;
    logic [15:0]        r_init_cnt;
    ref_state_t         r_ref_state;
    logic [15:0]        r_ref_cnt;
    logic [15:0]        r_ref_len;
    logic               r_ref_ack;
    logic               r_wcmd_pending;
    logic [MEM_AW-1:0]  r_widx;
    logic [DATA_W-1:0]  r_fifo_data [2];
    logic [c_bytes-1:0] r_fifo_mask [2];
    logic               r_fifo_wptr;
    logic               r_fifo_rptr;
    logic [1:0]         r_fifo_cnt;
    logic [RD_LAT-2:0]  r_pv;
    logic [DATA_W-1:0]  r_pd [RD_LAT-1];
    logic               r_err;

    logic               w_ref_busy;
    logic               w_acc;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic               w_bad_acc;
    logic               w_push;
    logic               w_commit;
    logic [MEM_AW-1:0]  w_cidx;
    logic [DATA_W-1:0]  w_merged;
    logic [DATA_W-1:0]  w_rd_sample;
    logic               w_unused_addr;

    // Column bits and bits above the RAM index alias silently.
    assign w_unused_addr = ^{addr[ADDR_W-1:MEM_AW+3], addr[2:0]};

    assign w_ref_busy = (r_ref_state == REF_BUSY);
    assign cmd_ready  = r_init_done & ~w_ref_busy & ~r_wcmd_pending;
    assign wr_data_rdy = r_init_done & (r_fifo_cnt < 2'd2);
    assign init_calib_complete = r_init_done;
    assign ref_ack    = r_ref_ack;
    assign err        = r_err;

    assign w_acc     = cmd_en & cmd_ready;
    assign w_wr_acc  = w_acc & (cmd == 3'b000);
    assign w_rd_acc  = w_acc & (cmd == 3'b001);
    assign w_bad_acc = w_acc & (cmd[2:1] != 2'b00);
    assign w_push    = wr_data_en & wr_data_rdy;
    assign w_commit  = r_wcmd_pending & (r_fifo_cnt != 2'd0);
    assign w_cidx    = addr[MEM_AW+2:3];

    // Byte-merge the FIFO head over the current RAM word at the write index.
    always_comb begin
        w_merged = r_ram[r_widx];
        for (int b = 0; b < c_bytes; b++) begin
            if (!r_fifo_mask[r_fifo_rptr][b]) begin
                w_merged[b*8 +: 8] = r_fifo_data[r_fifo_rptr][b*8 +: 8];
            end
        end
    end

    // Same-cycle commit to the read index is forwarded so reads see it.
    assign w_rd_sample = (w_commit && (r_widx == w_cidx)) ? w_merged : r_ram[w_cidx];

    // Backing RAM; deliberately not reset so contents survive a reset.
    always_ff @(posedge ui_clk) begin
        if (w_commit) begin
            r_ram[r_widx] <= w_merged;
        end
    end

    // Write-data FIFO storage.
    always_ff @(posedge ui_clk) begin
        if (w_push) begin
            r_fifo_data[r_fifo_wptr] <= wr_data;
            r_fifo_mask[r_fifo_wptr] <= wr_data_mask;
        end
    end

    // Write-data FIFO pointers and occupancy.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_fifo_wptr <= 1'b0;
            r_fifo_rptr <= 1'b0;
            r_fifo_cnt  <= 2'd0;
        end else begin
            if (w_push)   r_fifo_wptr <= ~r_fifo_wptr;
            if (w_commit) r_fifo_rptr <= ~r_fifo_rptr;
            case ({w_push, w_commit})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // Outstanding write command waiting for its data beat.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_wcmd_pending <= 1'b0;
        end else if (w_wr_acc) begin
            r_wcmd_pending <= 1'b1;
            r_widx         <= w_cidx;
        end else if (w_commit) begin
            r_wcmd_pending <= 1'b0;
        end
    end

    // Calibration delay after reset release.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_init_cnt  <= 16'd0;
            r_init_done <= 1'b0;
        end else if (!r_init_done) begin
            if (r_init_cnt == c_init_last) r_init_done <= 1'b1;
            else                           r_init_cnt  <= r_init_cnt + 16'd1;
        end
    end

    // Refresh scheduler: interval timer or request opens a fixed-length window.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_ref_state <= REF_IDLE;
            r_ref_cnt   <= 16'd0;
            r_ref_len   <= 16'd0;
            r_ref_ack   <= 1'b0;
        end else begin
            r_ref_ack <= 1'b0;
            case (r_ref_state)
                REF_IDLE: begin
                    if (r_init_done) begin
                        if ((r_ref_cnt == c_ref_last) || ref_req) begin
                            r_ref_state <= REF_BUSY;
                            r_ref_len   <= 16'd0;
                        end else begin
                            r_ref_cnt <= r_ref_cnt + 16'd1;
                        end
                    end
                end
                REF_BUSY: begin
                    if (r_ref_len == c_len_last) begin
                        r_ref_state <= REF_IDLE;
                        r_ref_ack   <= 1'b1;
                        r_ref_cnt   <= 16'd0;
                    end else begin
                        r_ref_len <= r_ref_len + 16'd1;
                    end
                end
                default: r_ref_state <= REF_IDLE;
            endcase
        end
    end

    // Read data pipeline; data stages need no reset since valid gates them.
    always_ff @(posedge ui_clk) begin
        r_pd[0] <= w_rd_sample;
        for (int i = 1; i < RD_LAT - 1; i++) begin
            r_pd[i] <= r_pd[i-1];
        end
    end

    // Read valid pipeline and output register; rd_data holds between beats.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_pv          <= '0;
            rd_data_valid <= 1'b0;
            rd_data_end   <= 1'b0;
            rd_data       <= '0;
        end else begin
            r_pv[0] <= w_rd_acc;
            for (int i = 1; i < RD_LAT - 1; i++) begin
                r_pv[i] <= r_pv[i-1];
            end
            rd_data_valid <= r_pv[RD_LAT-2];
            rd_data_end   <= r_pv[RD_LAT-2];
            if (r_pv[RD_LAT-2]) rd_data <= r_pd[RD_LAT-2];
        end
    end

    // Sticky protocol error flag.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_err <= 1'b0;
        end else if (w_bad_acc || (wr_data_en && !wr_data_end) ||
                     ((cmd_en || wr_data_en) && !r_init_done)) begin
            r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr3_ui_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_ui_responder
// Brief    : Directed self-checking bench for ddr3_ui_responder with a
//            reference memory model and an expected-read scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr3_ui_responder;

    localparam int RD_LAT = 4;

    logic          ui_clk = 1'b0;
    logic          ui_clk_sync_rst;
    logic [2:0]    cmd;
    logic          cmd_en;
    logic [28:0]   addr;
    logic          cmd_ready;
    logic [255:0]  wr_data;
    logic          wr_data_en;
    logic          wr_data_end;
    logic [31:0]   wr_data_mask;
    logic          wr_data_rdy;
    logic [255:0]  rd_data;
    logic          rd_data_valid;
    logic          rd_data_end;
    logic          ref_req;
    logic          ref_ack;
    logic          init_calib_complete;
    logic          err;

    ddr3_ui_responder dut (
        .ui_clk              (ui_clk),
        .ui_clk_sync_rst     (ui_clk_sync_rst),
        .cmd                 (cmd),
        .cmd_en              (cmd_en),
        .addr                (addr),
        .cmd_ready           (cmd_ready),
        .wr_data             (wr_data),
        .wr_data_en          (wr_data_en),
        .wr_data_end         (wr_data_end),
        .wr_data_mask        (wr_data_mask),
        .wr_data_rdy         (wr_data_rdy),
        .rd_data             (rd_data),
        .rd_data_valid       (rd_data_valid),
        .rd_data_end         (rd_data_end),
        .ref_req             (ref_req),
        .ref_ack             (ref_ack),
        .init_calib_complete (init_calib_complete),
        .err                 (err)
    );

    always #5 ui_clk = ~ui_clk;

    int cyc = 0;
    always @(posedge ui_clk) cyc <= cyc + 1;

    typedef struct {
        logic [255:0] d;
        int           due;
    } rd_exp_t;

    typedef struct {
        logic [255:0] d;
        logic [31:0]  m;
    } beat_t;

    rd_exp_t      sbq[$];
    beat_t        beatq[$];
    rd_exp_t      e;
    logic [255:0] mem [256];
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one write beat and wait (bounded) for it to be taken.
    task automatic send_beat(input logic [255:0] d, input logic [31:0] m);
        bit    ok;
        beat_t b;
        ok = 1'b0;
        wr_data = d; wr_data_mask = m; wr_data_en = 1'b1; wr_data_end = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (wr_data_rdy) begin ok = 1'b1; break; end
            @(negedge ui_clk);
        end
        check("beat_accept", ok, 1);
        if (ok) @(negedge ui_clk);
        wr_data_en = 1'b0; wr_data_end = 1'b0;
        if (ok) begin b.d = d; b.m = m; beatq.push_back(b); end
    endtask

    // Issue one command; writes update the model, tracked reads feed the scoreboard.
    task automatic issue(input logic [2:0] c, input logic [28:0] a, input bit track);
        bit      ok;
        int      acc;
        beat_t   b;
        rd_exp_t x;
        ok = 1'b0;
        cmd = c; addr = a; cmd_en = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            @(negedge ui_clk);
        end
        acc = cyc;
        check("cmd_accept", ok, 1);
        if (ok) @(negedge ui_clk);
        cmd_en = 1'b0;
        if (ok && c == 3'b000 && beatq.size() != 0) begin
            b = beatq.pop_front();
            for (int i = 0; i < 32; i++) begin
                if (!b.m[i]) mem[a[10:3]][i*8 +: 8] = b.d[i*8 +: 8];
            end
        end
        if (ok && c == 3'b001 && track) begin
            x.d = mem[a[10:3]];
            x.due = acc + RD_LAT;
            sbq.push_back(x);
        end
    endtask

    // Read-return monitor: every valid beat must match the head of the scoreboard.
    always @(negedge ui_clk) begin
        if (rd_data_valid === 1'b1) begin
            check("rd_expected", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("rd_data", rd_data, e.d);
                check("rd_end", rd_data_end, 1);
                check("rd_latency", cyc, e.due);
            end
        end
    end

    initial begin
        int  lowcnt;
        int  vcnt;
        bit  ok;
        ui_clk_sync_rst = 1'b1;
        cmd = 3'b000; cmd_en = 1'b0; addr = '0;
        wr_data = '0; wr_data_en = 1'b0; wr_data_end = 1'b0; wr_data_mask = '0;
        ref_req = 1'b0;

        repeat (3) @(negedge ui_clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_wr_data_rdy", wr_data_rdy, 0);
        check("rst_rd_valid", rd_data_valid, 0);
        check("rst_rd_end", rd_data_end, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_ref_ack", ref_ack, 0);
        check("rst_init", init_calib_complete, 0);
        check("rst_err", err, 0);

        // Calibration completes exactly 16 cycles after reset release.
        ui_clk_sync_rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge ui_clk);
            if (i == 15) begin
                check("init_early", init_calib_complete, 0);
                check("cmd_ready_pre_init", cmd_ready, 0);
                check("wr_rdy_pre_init", wr_data_rdy, 0);
            end
            if (i == 16) check("init_on_time", init_calib_complete, 1);
        end

        // Basic write then read.
        send_beat({32{8'hA5}}, 32'h0);
        issue(3'b000, 29'h10, 1'b0);
        issue(3'b001, 29'h10, 1'b1);

        // Masked write over all-ones leaves only byte 0 changed.
        send_beat({256{1'b1}}, 32'h0);
        issue(3'b000, 29'h20, 1'b0);
        send_beat('0, 32'hFFFF_FFFE);
        issue(3'b000, 29'h20, 1'b0);
        issue(3'b001, 29'h20, 1'b1);

        // Data ahead of commands fills the FIFO, then drains in order.
        send_beat({8{32'hDEAD_BEEF}}, 32'h0);
        send_beat({8{32'h0123_4567}}, 32'h0);
        check("fifo_full_rdy", wr_data_rdy, 0);
        issue(3'b000, 29'h40, 1'b0);
        issue(3'b000, 29'h48, 1'b0);
        issue(3'b001, 29'h40, 1'b1);
        issue(3'b001, 29'h48, 1'b1);
        issue(3'b001, 29'h10, 1'b1);
        issue(3'b001, 29'h20, 1'b1);
        repeat (6) @(negedge ui_clk);

        // Requested refresh with a read already in flight.
        issue(3'b001, 29'h48, 1'b1);
        ref_req = 1'b1;
        @(negedge ui_clk);
        ref_req = 1'b0;
        lowcnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (!cmd_ready && !ref_ack) lowcnt++;
            @(negedge ui_clk);
        end
        check("ref_busy_cycles", lowcnt, 6);
        check("ref_ack_pulse", ref_ack, 1);
        check("cmd_ready_after_ref", cmd_ready, 1);
        @(negedge ui_clk);
        check("ref_ack_single", ref_ack, 0);
        repeat (6) @(negedge ui_clk);

        // Illegal command sets a sticky error.
        check("err_clear", err, 0);
        issue(3'b010, 29'h10, 1'b0);
        check("err_set", err, 1);
        repeat (3) @(negedge ui_clk);
        check("err_sticky", err, 1);

        // Reset in the middle of a read drops it; RAM survives.
        issue(3'b001, 29'h10, 1'b0);
        ui_clk_sync_rst = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ui_clk);
            if (rd_data_valid !== 1'b0) vcnt++;
            if (i == 2) ui_clk_sync_rst = 1'b0;
        end
        check("no_valid_after_rst", vcnt, 0);
        check("rd_data_after_rst", rd_data, 0);
        check("err_after_rst", err, 0);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (init_calib_complete) begin ok = 1'b1; break; end
            @(negedge ui_clk);
        end
        check("reinit", ok, 1);
        issue(3'b001, 29'h10, 1'b1);
        issue(3'b001, 29'h40, 1'b1);

        for (int n = 0; n < 20 && sbq.size() != 0; n++) @(negedge ui_clk);
        check("scoreboard_drained", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
